sl_fanout_cell: RTL
===================

# sl_fanout_cell

Parametrised 1-to-N same-latency fanout cell. It succeeds the fixed 2-way split cell and lets a same-latency tree be built from a single cell type with any radix. A host request is registered through DOWN_PIPE stages and decoded on an address bit-field to one of N_DOWN slaves. The selected slave's response is returned to the host at a fixed, decode-independent latency; a tag delay line steers the response mux and checks slave timing.

## Interface
Parameters:
- N_DOWN, 4, downstream port count (2..16); SEL_W = $clog2(N_DOWN)
- SEL_LSB, 10, LSB of the select field req_addr[SEL_LSB +: SEL_W]
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DOWN_PIPE, 2, request register stages (>=1)
- UP_PIPE, 2, response register stages (>=1)
- SLAVE_LAT, 1, fixed slave latency: slave req accepted in cycle t, response in cycle t+SLAVE_LAT (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- host_req_valid  in  1  request strobe, no backpressure
- host_req_wr  in  1  1 = write, 0 = read
- host_req_addr  in  ADDR_W  address
- host_req_wdata  in  DATA_W  write data
- host_res_valid  out  1  response strobe
- host_res_rdata  out  DATA_W  read data
- host_res_err  out  1  decode-error response (only with macro)
- slave_req_valid  out  N_DOWN  one-hot per-slave strobe
- slave_req_wr  out  N_DOWN  per-slave write flag
- slave_req_addr  out  N_DOWN*ADDR_W  per-slave address, slice i for slave i
- slave_req_wdata  out  N_DOWN*DATA_W  per-slave write data
- slave_res_valid  in  N_DOWN  per-slave response strobe
- slave_res_rdata  in  N_DOWN*DATA_W  per-slave read data
- lat_err  out  1  sticky: expected slave response missing or unexpected response seen

## Operation
- Request path: DOWN_PIPE stage shift of {valid, wr, addr, wdata}. The last stage decodes sel; if sel < N_DOWN, only slave_req_valid[sel] is asserted. addr/wdata/wr are broadcast to all slices; only valid is gated.
- Out-of-range (sel >= N_DOWN; possible only for non-power-of-2 N_DOWN): no slave_req_valid is asserted.
- Tag line: each issued request pushes {valid, sel, oor} into a SLAVE_LAT-deep shift register, in step with the slave outputs. Reads and writes both produce a response.
- Response capture at tag-line tail with valid=1 and oor=0: take slave_res_rdata[sel] into UP_PIPE stage 1 with valid=1.
- Timing check: set lat_err if tail valid && !oor && !slave_res_valid[sel]. Also set it if any slave_res_valid[i] is high while the tail does not expect slave i. lat_err clears only on reset.
- One request per cycle; back-to-back requests to different slaves return in issue order, one per cycle.
- Reset mid-operation clears every pipe, tag line and lat_err; in-flight transactions are lost and no response is produced for them.
- Reset values: all outputs 0.

## Timing
- host_req cycle t -> slave_req_valid cycle t+DOWN_PIPE -> slave_res cycle t+DOWN_PIPE+SLAVE_LAT -> host_res_valid cycle t+DOWN_PIPE+SLAVE_LAT+UP_PIPE.
- Default total latency: 5 cycles, identical for every slave index.
- Full throughput: no bubbles, no stalls, no backpressure.

## Configuration
- SL_FANOUT_ERR_RESP_EN defined: an out-of-range request still travels the tag line with oor=1. It produces host_res_valid=1, host_res_err=1, host_res_rdata=0 at the normal latency.
- SL_FANOUT_ERR_RESP_EN undefined: out-of-range requests are silently dropped (no host response), and host_res_err is tied to 0.

## Test plan
- Defaults; read addr 0x0000_0C00 (sel=3), slave 3 returns 0xA5A5_0003 one cycle after its strobe -> slave_req_valid=4'b1000 at t+2, host_res_valid with 0xA5A5_0003 at t+5, lat_err=0.
- Four back-to-back reads, sel 0,1,2,3, each slave returning 0x1000+i -> responses 0x1000..0x1003 on consecutive cycles t+5..t+8.
- N_DOWN=3, read sel=3, macro defined -> no slave strobe, host_res_valid=1, host_res_err=1, rdata=0 at t+5. Macro undefined -> no host_res_valid.
- Slave 2 withholds its response -> lat_err=1 at t+3 and stays 1; slave 1 pulses res_valid unprompted -> lat_err=1.
- Assert rst_n=0 for one cycle at t+3 of an in-flight read -> all outputs 0 immediately, no response at t+5, lat_err=0.
- DOWN_PIPE=1, UP_PIPE=3, SLAVE_LAT=2, write addr 0x400 (sel=1) -> slave_req_valid[1] at t+1 with wr=1, host_res_valid at t+6.

Source files
------------

// File: rtl/sl_fanout_cell.sv
// ---------------------------------------------------------------------------
// sl_fanout_cell
//
// Parametrised 1-to-N same-latency fanout cell. A host request is registered
// through DOWN_PIPE stages and then decoded on req_addr[SEL_LSB +: SEL_W] to
// one of N_DOWN slaves. A SLAVE_LAT-deep tag line follows each issued request
// so that the matching slave response can be steered back to the host. The
// response then passes through UP_PIPE registers. The total latency is
// DOWN_PIPE + SLAVE_LAT + UP_PIPE for every slave index.
//
// Optional feature macro: SL_FANOUT_ERR_RESP_EN
//   defined   : out-of-range selects return host_res_err=1, rdata=0 at the
//               normal latency
//   undefined : out-of-range selects are dropped, and host_res_err is held
//               at 0
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   host_req_*          host request: valid, wr, addr, wdata (no backpressure)
//   host_res_*          host response: valid, rdata, err
//   slave_req_*         per-slave request; valid is one-hot, while wr, addr
//                       and wdata are broadcast to every slice
//   slave_res_*         per-slave response: valid, rdata
//   lat_err             sticky slave-timing violation flag
// ---------------------------------------------------------------------------
module sl_fanout_cell #(
  parameter int N_DOWN    = 4,
  parameter int SEL_LSB   = 10,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DOWN_PIPE = 2,
  parameter int UP_PIPE   = 2,
  parameter int SLAVE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_req_valid,
  input  logic                     host_req_wr,
  input  logic [ADDR_W-1:0]        host_req_addr,
  input  logic [DATA_W-1:0]        host_req_wdata,
  output logic                     host_res_valid,
  output logic [DATA_W-1:0]        host_res_rdata,
  output logic                     host_res_err,
  output logic [N_DOWN-1:0]        slave_req_valid,
  output logic [N_DOWN-1:0]        slave_req_wr,
  output logic [N_DOWN*ADDR_W-1:0] slave_req_addr,
  output logic [N_DOWN*DATA_W-1:0] slave_req_wdata,
  input  logic [N_DOWN-1:0]        slave_res_valid,
  input  logic [N_DOWN*DATA_W-1:0] slave_res_rdata,
  output logic                     lat_err
);

  localparam int SEL_W = $clog2(N_DOWN);

`ifdef SL_FANOUT_ERR_RESP_EN
  localparam logic ERR_RESP_EN = 1'b1;
`else
  localparam logic ERR_RESP_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Request pipe
  // -------------------------------------------------------------------------
  logic [DOWN_PIPE-1:0]             req_valid_q;
  logic [DOWN_PIPE-1:0]             req_wr_q;
  logic [DOWN_PIPE-1:0][ADDR_W-1:0] req_addr_q;
  logic [DOWN_PIPE-1:0][DATA_W-1:0] req_wdata_q;

  // Address and data are reset as well, because every output must read 0
  // while the cell is in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= '0;
      req_wr_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      req_valid_q[0] <= host_req_valid;
      req_wr_q[0]    <= host_req_wr;
      req_addr_q[0]  <= host_req_addr;
      req_wdata_q[0] <= host_req_wdata;
      for (int k = 1; k < DOWN_PIPE; k++) begin
        req_valid_q[k] <= req_valid_q[k-1];
        req_wr_q[k]    <= req_wr_q[k-1];
        req_addr_q[k]  <= req_addr_q[k-1];
        req_wdata_q[k] <= req_wdata_q[k-1];
      end
    end
  end

  logic              iss_valid;
  logic              iss_wr;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic [SEL_W-1:0]  iss_sel;
  logic              iss_oor;

  assign iss_valid = req_valid_q[DOWN_PIPE-1];
  assign iss_wr    = req_wr_q[DOWN_PIPE-1];
  assign iss_addr  = req_addr_q[DOWN_PIPE-1];
  assign iss_wdata = req_wdata_q[DOWN_PIPE-1];
  assign iss_sel   = iss_addr[SEL_LSB +: SEL_W];
  // Widened by one bit so the comparison still works for power-of-2 N_DOWN.
  // In that case the comparison is never true.
  assign iss_oor   = ({1'b0, iss_sel} >= (SEL_W+1)'(N_DOWN));

  // -------------------------------------------------------------------------
  // Tag line: {valid, sel, oor}, which moves in step with the slave latency
  // -------------------------------------------------------------------------
  logic                            tag_push;
  logic [SLAVE_LAT-1:0]            tag_valid_q;
  logic [SLAVE_LAT-1:0]            tag_oor_q;
  logic [SLAVE_LAT-1:0][SEL_W-1:0] tag_sel_q;

  // Out-of-range requests enter the tag line only when they must produce an
  // error response. Otherwise they are dropped here.
  assign tag_push = iss_valid & (ERR_RESP_EN | ~iss_oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q <= '0;
      tag_oor_q   <= '0;
      tag_sel_q   <= '0;
    end else begin
      tag_valid_q[0] <= tag_push;
      tag_oor_q[0]   <= iss_oor;
      tag_sel_q[0]   <= iss_sel;
      for (int k = 1; k < SLAVE_LAT; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_oor_q[k]   <= tag_oor_q[k-1];
        tag_sel_q[k]   <= tag_sel_q[k-1];
      end
    end
  end

  logic             tail_valid;
  logic             tail_oor;
  logic [SEL_W-1:0] tail_sel;

  assign tail_valid = tag_valid_q[SLAVE_LAT-1];
  assign tail_oor   = tag_oor_q[SLAVE_LAT-1];
  assign tail_sel   = tag_sel_q[SLAVE_LAT-1];

  // -------------------------------------------------------------------------
  // Per-slave fanout and the expected-response vector
  // -------------------------------------------------------------------------
  logic [N_DOWN-1:0] res_expect;

  genvar gi;
  for (gi = 0; gi < N_DOWN; gi++) begin : g_port
    assign slave_req_valid[gi]                   = iss_valid & (iss_sel == SEL_W'(gi));
    assign slave_req_wr[gi]                      = iss_wr;
    assign slave_req_addr[gi*ADDR_W +: ADDR_W]   = iss_addr;
    assign slave_req_wdata[gi*DATA_W +: DATA_W]  = iss_wdata;
    assign res_expect[gi] = tail_valid & ~tail_oor & (tail_sel == SEL_W'(gi));
  end

  // res_expect is one-hot or zero. The OR-reduction therefore selects the
  // expected slave, and it yields 0 for an out-of-range tail.
  logic [DATA_W-1:0] cap_rdata;

  always_comb begin
    cap_rdata = '0;
    for (int i = 0; i < N_DOWN; i++) begin
      if (res_expect[i]) begin
        cap_rdata = cap_rdata | slave_res_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A missing expected response and an unsolicited response both show up
  // as a bit difference between the two vectors.
  logic timing_err;
  logic lat_err_q;

  assign timing_err = |(res_expect ^ slave_res_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_err_q <= 1'b0;
    end else begin
      lat_err_q <= lat_err_q | timing_err;
    end
  end

  // The flag is raised in the same cycle that the violation is seen. It is
  // masked during reset so that the output reads 0 while rst_n is low.
  assign lat_err = lat_err_q | (timing_err & rst_n);

  // -------------------------------------------------------------------------
  // Response pipe
  // -------------------------------------------------------------------------
  logic [UP_PIPE-1:0]             up_valid_q;
  logic [UP_PIPE-1:0][DATA_W-1:0] up_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid_q <= '0;
      up_rdata_q <= '0;
    end else begin
      up_valid_q[0] <= tail_valid;
      up_rdata_q[0] <= cap_rdata;
      for (int k = 1; k < UP_PIPE; k++) begin
        up_valid_q[k] <= up_valid_q[k-1];
        up_rdata_q[k] <= up_rdata_q[k-1];
      end
    end
  end

  assign host_res_valid = up_valid_q[UP_PIPE-1];
  assign host_res_rdata = up_rdata_q[UP_PIPE-1];

`ifdef SL_FANOUT_ERR_RESP_EN
  logic [UP_PIPE-1:0] up_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_err_q <= '0;
    end else begin
      up_err_q[0] <= tail_valid & tail_oor;
      for (int k = 1; k < UP_PIPE; k++) begin
        up_err_q[k] <= up_err_q[k-1];
      end
    end
  end

  assign host_res_err = up_err_q[UP_PIPE-1];
`else
  assign host_res_err = 1'b0;
`endif

endmodule
